systolic_matmul_nxn: RTL and testbench

Parametrised NxN output-stationary systolic matrix multiplier computing C = A x B. A is NxK and B is KxN, with K selectable at run time. Operands stream in one k-slice per beat: column k of A and row k of B. Skewing is done internally, and results drain one row per beat through a valid/ready port. This block is the generalised successor to the fixed 3x3 MAC array and adds run-time K, signed/unsigned mode, input bubbles, backpressure and a done flag.

---
 rtl/systolic_pkg.sv | 46 ++++
 rtl/systolic_pe.sv | 59 +++++
 rtl/systolic_matmul_nxn.sv | 222 ++++++++++++++++++++++
 tb/tb_systolic_matmul_nxn.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM type, sizing helpers and the PE product function
// for the NxN output-stationary systolic matrix multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUT
    } state_e;

    // Widest operand/accumulator the product helper supports.
    localparam int unsigned PW = 128;

    function automatic int drain_cyc(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int rw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int N_DEF     = 3;
    localparam int DRAIN_CYC = drain_cyc(N_DEF);
    localparam int RW        = rw_of(N_DEF);

    // Extends both dw-bit operands per mode and multiplies; callers keep the
    // low ACC_W bits, which is the product modulo 2^ACC_W.
    function automatic logic [PW-1:0] sext_prod(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b,
        input int unsigned   dw,
        input logic          signed_mode
    );
        logic [PW-1:0] hi;
        logic [PW-1:0] sb;
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        hi = {PW{1'b1}} << dw;
        sb = {{(PW-1){1'b0}}, 1'b1} << (dw - 1);
        ea = (signed_mode && |(a & sb)) ? (a | hi) : (a & ~hi);
        eb = (signed_mode && |(b & sb)) ? (b | hi) : (b & ~hi);
        return ea * eb;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary cell; forwards a right and b down with
// one register each and accumulates when both operands are tagged valid.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              sm_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic              av_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              bv_i,
    output logic [DATA_W-1:0] a_o,
    output logic              av_o,
    output logic [DATA_W-1:0] b_o,
    output logic              bv_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              av_q;
    logic              bv_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  prod;

    assign prod = ACC_W'(sext_prod(PW'(a_i), PW'(b_i), DATA_W, sm_i));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            av_q  <= 1'b0;
            bv_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q  <= a_i;
            b_q  <= b_i;
            av_q <= av_i & ~clr_i;
            bv_q <= bv_i & ~clr_i;
            if (clr_i) begin
                acc_q <= '0;
            end else if (av_i && bv_i) begin
                acc_q <= acc_q + prod;
            end
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign av_o  = av_q;
    assign bv_o  = bv_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// systolic_matmul_nxn: NxN output-stationary C = A x B with run-time K,
// internal operand skew and a valid/ready result port draining one row a beat.
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int K_MAX  = 16,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic                  signed_mode,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_col,
    input  logic [N*DATA_W-1:0]   b_row,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N*ACC_W-1:0]    res_row,
    output logic [$clog2(N)-1:0]  res_idx,
    output logic                  done
);

    localparam int DC  = drain_cyc(N);
    localparam int DCW = $clog2(DC + 1);
    localparam int RWL = rw_of(N);

    state_e           state_q, state_d;
    logic [KW-1:0]    klen_q, klen_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [RWL-1:0]   r_q, r_d;
    logic             sm_q, sm_d;
    logic             clr;
    logic             beat;
    logic [KW-1:0]    kl_clamp;

    assign kl_clamp  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == LOAD);
    assign res_valid = (state_q == OUT);
    assign beat      = in_valid & in_ready;
    assign res_idx   = r_q;
    assign done      = res_valid & res_ready & (r_q == RWL'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            r_q     <= '0;
            sm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            r_q     <= r_d;
            sm_q    <= sm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        r_d     = r_q;
        sm_d    = sm_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    klen_d  = kl_clamp;
                    sm_d    = signed_mode;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    r_d     = '0;
                    state_d = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_d == klen_q) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end
            end
            DRAIN: begin
                // Long enough for the last beat to reach PE(N-1,N-1).
                if (dcnt_q == DCW'(DC - 1)) begin
                    state_d = OUT;
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (r_q == RWL'(N - 1)) begin
                        state_d = IDLE;
                        r_d     = '0;
                    end else begin
                        r_d = r_q + RWL'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [DATA_W-1:0] a_sk  [N];
    logic              a_skv [N];
    logic [DATA_W-1:0] b_sk  [N];
    logic              b_skv [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W-1:0] a_in;
        logic [DATA_W-1:0] b_in;
        assign a_in = a_col[i*DATA_W +: DATA_W];
        assign b_in = b_row[i*DATA_W +: DATA_W];
        if (i == 0) begin : g_direct
            assign a_sk[i]  = a_in;
            assign a_skv[i] = beat;
            assign b_sk[i]  = b_in;
            assign b_skv[i] = beat;
        end else begin : g_chain
            logic [DATA_W-1:0] ad_q [i];
            logic              av_q [i];
            logic [DATA_W-1:0] bd_q [i];
            logic              bv_q [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        ad_q[s] <= '0;
                        av_q[s] <= 1'b0;
                        bd_q[s] <= '0;
                        bv_q[s] <= 1'b0;
                    end
                end else begin
                    ad_q[0] <= a_in;
                    av_q[0] <= beat;
                    bd_q[0] <= b_in;
                    bv_q[0] <= beat;
                    for (int s = 1; s < i; s++) begin
                        ad_q[s] <= ad_q[s-1];
                        av_q[s] <= av_q[s-1];
                        bd_q[s] <= bd_q[s-1];
                        bv_q[s] <= bv_q[s-1];
                    end
                end
            end
            assign a_sk[i]  = ad_q[i-1];
            assign a_skv[i] = av_q[i-1];
            assign b_sk[i]  = bd_q[i-1];
            assign b_skv[i] = bv_q[i-1];
        end
    end

    logic [DATA_W-1:0] aw  [N][N];
    logic              avw [N][N];
    logic [DATA_W-1:0] bw  [N][N];
    logic              bvw [N][N];
    logic [DATA_W-1:0] ax  [N][N];
    logic              avx [N][N];
    logic [DATA_W-1:0] bx  [N][N];
    logic              bvx [N][N];
    logic [ACC_W-1:0]  acc [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_aw
                assign aw[i][j]  = a_sk[i];
                assign avw[i][j] = a_skv[i];
            end else begin : g_an
                assign aw[i][j]  = ax[i][j-1];
                assign avw[i][j] = avx[i][j-1];
            end
            if (i == 0) begin : g_bw
                assign bw[i][j]  = b_sk[j];
                assign bvw[i][j] = b_skv[j];
            end else begin : g_bn
                assign bw[i][j]  = bx[i-1][j];
                assign bvw[i][j] = bvx[i-1][j];
            end
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr),
                .sm_i  (sm_q),
                .a_i   (aw[i][j]),
                .av_i  (avw[i][j]),
                .b_i   (bw[i][j]),
                .bv_i  (bvw[i][j]),
                .a_o   (ax[i][j]),
                .av_o  (avx[i][j]),
                .b_o   (bx[i][j]),
                .bv_o  (bvx[i][j]),
                .acc_o (acc[i][j])
            );
        end
    end

    always_comb begin
        res_row = '0;
        for (int j = 0; j < N; j++) begin
            res_row[j*ACC_W +: ACC_W] = res_valid ? acc[r_q][j] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// tb_systolic_matmul_nxn: directed jobs with hand-computed results for the
// 3x3 systolic multiplier, including bubbles, backpressure and mid-job reset.
module tb_systolic_matmul_nxn;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 64;
    localparam int KM = 16;
    localparam int KW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            signed_mode;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;
    logic            res_valid;
    logic            res_ready;
    logic [N*AW-1:0] res_row;
    logic [1:0]      res_idx;
    logic            done;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] A [N][KM];
    logic [DW-1:0] B [KM][N];
    logic [AW-1:0] C [N][N];

    always #5 clk = ~clk;

    systolic_matmul_nxn #(
        .N      (N),
        .DATA_W (DW),
        .ACC_W  (AW),
        .K_MAX  (KM),
        .KW     (KW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_col       (a_col),
        .b_row       (b_row),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_row     (res_row),
        .res_idx     (res_idx),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [AW-1:0] obs,
                       input logic [AW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                        input logic [AW-1:0] cv);
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < N; i++) begin
                A[i][k] = av;
                B[k][i] = bv;
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                C[i][j] = cv;
            end
        end
    endtask

    task automatic fill_ident();
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < N; i++) begin
                A[i][k] = (i == k) ? 32'd1 : 32'd0;
                B[k][i] = DW'(3 * k + i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                C[i][j] = AW'(3 * i + j + 1);
            end
        end
    endtask

    // A[i][k] = i+1, B[k][j] = k+j, K=4 -> C[i][j] = (i+1)*(6+4j)
    task automatic fill_ramp();
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < N; i++) begin
                A[i][k] = DW'(i + 1);
                B[k][i] = DW'(k + i);
            end
        end
        C[0][0] = 64'd6;  C[0][1] = 64'd10; C[0][2] = 64'd14;
        C[1][0] = 64'd12; C[1][1] = 64'd20; C[1][2] = 64'd28;
        C[2][0] = 64'd18; C[2][1] = 64'd30; C[2][2] = 64'd42;
    endtask

    task automatic run_job(input string tag, input int kl_drv, input int kl,
                           input logic sm, input int bub_at, input int bub_len,
                           input int hold_row, input int hold_len,
                           input int lat);
        int k;
        int t;
        int bub;
        int guard;
        logic seen;
        chk({tag, ".idle"}, AW'(busy), 64'd0);
        start       = 1'b1;
        k_len       = KW'(kl_drv);
        signed_mode = sm;
        step();
        start = 1'b0;
        t     = 1;
        k     = 0;
        bub   = 0;
        guard = 0;
        while (k < kl && guard < 100) begin
            if (k == bub_at && bub < bub_len) begin
                in_valid = 1'b0;
                bub++;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    a_col[i*DW +: DW] = A[i][k];
                    b_row[i*DW +: DW] = B[k][i];
                end
            end
            #1;
            if (in_valid && in_ready) k++;
            step();
            t++;
            guard++;
        end
        in_valid = 1'b0;
        chk({tag, ".feed_bound"}, AW'(guard < 100), 64'd1);
        #1;
        chk({tag, ".ready_drop"}, AW'(in_ready), 64'd0);
        guard = 0;
        seen  = 1'b0;
        while (!res_valid && guard < 100) begin
            if (in_ready) seen = 1'b1;
            step();
            t++;
            guard++;
        end
        chk({tag, ".valid_seen"}, AW'(res_valid), 64'd1);
        chk({tag, ".no_ready"}, AW'(seen), 64'd0);
        if (lat >= 0) chk({tag, ".latency"}, AW'(t), AW'(lat));
        for (int r = 0; r < N; r++) begin
            if (r == hold_row) begin
                for (int h = 0; h < hold_len; h++) begin
                    res_ready = 1'b0;
                    start     = 1'b1;
                    k_len     = '0;
                    #1;
                    chk($sformatf("%s.hold%0d.idx", tag, h), AW'(res_idx), AW'(r));
                    chk($sformatf("%s.hold%0d.c0", tag, h), res_row[0 +: AW], C[r][0]);
                    chk($sformatf("%s.hold%0d.c2", tag, h), res_row[2*AW +: AW], C[r][2]);
                    chk($sformatf("%s.hold%0d.done", tag, h), AW'(done), 64'd0);
                    step();
                end
            end
            start     = 1'b0;
            res_ready = 1'b1;
            #1;
            chk($sformatf("%s.r%0d.valid", tag, r), AW'(res_valid), 64'd1);
            chk($sformatf("%s.r%0d.idx", tag, r), AW'(res_idx), AW'(r));
            for (int j = 0; j < N; j++) begin
                chk($sformatf("%s.c%0d%0d", tag, r, j), res_row[j*AW +: AW], C[r][j]);
            end
            chk($sformatf("%s.r%0d.done", tag, r), AW'(done), AW'(r == N - 1));
            step();
        end
        res_ready = 1'b0;
        #1;
        chk({tag, ".end_busy"}, AW'(busy), 64'd0);
        chk({tag, ".end_done"}, AW'(done), 64'd0);
        chk({tag, ".end_valid"}, AW'(res_valid), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        k_len       = '0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        res_ready   = 1'b0;
        a_col       = '0;
        b_row       = '0;
        #1 rst = 1'b0;
        #11;
        chk("rst.busy", AW'(busy), 64'd0);
        chk("rst.in_ready", AW'(in_ready), 64'd0);
        chk("rst.res_valid", AW'(res_valid), 64'd0);
        chk("rst.res_row", res_row[AW-1:0], 64'd0);
        chk("rst.res_idx", AW'(res_idx), 64'd0);
        chk("rst.done", AW'(done), 64'd0);
        rst = 1'b1;
        step();

        fill_ident();
        run_job("ident", 3, 3, 1'b0, -1, 0, -1, 0, 9);

        fill(32'hFFFF_FFFF, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        run_job("signed", 2, 2, 1'b1, -1, 0, -1, 0, 8);

        fill(32'hFFFF_FFFF, 32'd3, 64'h0000_0005_FFFF_FFFA);
        run_job("unsigned", 2, 2, 1'b0, -1, 0, -1, 0, 8);

        fill_ramp();
        run_job("bubble", 4, 4, 1'b0, 2, 2, -1, 0, 12);
        run_job("hold", 4, 4, 1'b0, -1, 0, 1, 5, 10);

        fill(32'd0, 32'd0, 64'd0);
        run_job("kzero", 0, 0, 1'b0, -1, 0, -1, 0, 6);

        fill(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFE0_0000_0010);
        run_job("kmax", 20, 16, 1'b0, -1, 0, -1, 0, 22);

        fill_ident();
        start       = 1'b1;
        k_len       = 5'd3;
        signed_mode = 1'b0;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = A[i][0];
            b_row[i*DW +: DW] = B[0][i];
        end
        step();
        #2 rst = 1'b0;
        #1;
        chk("abort.busy", AW'(busy), 64'd0);
        chk("abort.in_ready", AW'(in_ready), 64'd0);
        chk("abort.res_valid", AW'(res_valid), 64'd0);
        chk("abort.res_row", res_row[AW-1:0], 64'd0);
        chk("abort.res_idx", AW'(res_idx), 64'd0);
        chk("abort.done", AW'(done), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        run_job("post_rst", 3, 3, 1'b0, -1, 0, -1, 0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
